// File: rtl/h14tx_pkg.sv
// h14tx shared types: period codes from the timing generator and
// packet-scheduler slot constants.
package h14tx_pkg;

    typedef enum logic [2:0] {
        Control,
        VideoPreamble,
        VideoGuard,
        VideoActive,
        DataPreamble,
        DataGuard,
        DataIslandActive
    } period_t;

    localparam int SlotClocks      = 32;
    localparam int PacketHardLimit = 18;

    typedef logic [4:0] slot_idx_t;

    typedef enum logic [0:0] {
        Idle,
        Slot
    } sched_state_e;

endpackage

// File: rtl/h14tx_packet_scheduler_if.sv
// Scheduler bus: timing/request inputs and slot/grant outputs.
// master = scheduler side, slave = timing generator / serializer side.
interface h14tx_packet_scheduler_if #(
    parameter int NumSources = 4
);
    import h14tx_pkg::*;

    period_t                timings;
    logic [NumSources-1:0]  req;
    logic [NumSources-1:0]  grant;
    logic                   null_grant;
    logic                   slot_start;
    slot_idx_t              slot_idx;
    logic [4:0]             pkt_idx;
    logic [NumSources-1:0]  ack;
    logic                   slot_abort;
    logic                   overrun;

    modport master (
        input  timings, req,
        output grant, null_grant, slot_start, slot_idx,
        output pkt_idx, ack, slot_abort, overrun
    );

    modport slave (
        output timings, req,
        input  grant, null_grant, slot_start, slot_idx,
        input  pkt_idx, ack, slot_abort, overrun
    );

endinterface

// File: rtl/h14tx_sched_arbiter.sv
// Combinational one-hot winner: first requester found searching
// upward (with wrap) from the pointer.
module h14tx_sched_arbiter #(
    parameter int NumSources = 4,
    parameter int PtrW       = 2
) (
    input  logic [NumSources-1:0] req,
    input  logic [PtrW-1:0]       ptr,
    output logic [NumSources-1:0] winner
);

    int   k;
    logic found;

    // Rotated priority search starting at ptr
    always_comb begin
        winner = '0;
        found  = 1'b0;
        k      = 0;
        for (int i = 0; i < NumSources; i++) begin
            k = (int'(ptr) + i) % NumSources;
            if (!found && req[k]) begin
                winner[k] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/h14tx_packet_scheduler.sv
// Data-island packet slot scheduler; outputs lag timings by one cycle.
// Define H14TX_SCHED_RR_EN for round-robin, else fixed priority (index 0).
module h14tx_packet_scheduler
    import h14tx_pkg::*;
#(
    parameter int NumSources = 4,
    parameter int MaxPackets = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    h14tx_packet_scheduler_if.master bus
);

    localparam int        PtrW     = (NumSources > 1) ? $clog2(NumSources) : 1;
    localparam logic [4:0] LastPkt = 5'(MaxPackets - 1);
    localparam slot_idx_t LastClk  = slot_idx_t'(SlotClocks - 1);
    localparam slot_idx_t PreLast  = slot_idx_t'(SlotClocks - 2);

    sched_state_e          state;
    logic [NumSources-1:0] winner;
    logic [PtrW-1:0]       ptr;
    logic                  inDi;
    logic                  fromIdle;
    logic                  startEdge;
    logic                  full;
    logic                  ackEdge;

    assign inDi      = (bus.timings == DataIslandActive);
    assign fromIdle  = (state == Idle);
    assign startEdge = inDi && (fromIdle || bus.slot_idx == LastClk);
    assign full      = !fromIdle && (bus.pkt_idx == LastPkt);
    assign ackEdge   = (state == Slot) && inDi && (bus.slot_idx == PreLast);

    h14tx_sched_arbiter #(
        .NumSources (NumSources),
        .PtrW       (PtrW)
    ) uArb (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (winner)
    );

`ifdef H14TX_SCHED_RR_EN
    logic [PtrW-1:0] nextPtr;

    // Pointer target: one past the currently granted source
    always_comb begin
        nextPtr = '0;
        for (int i = 0; i < NumSources; i++) begin
            if (bus.grant[i]) nextPtr = PtrW'((i + 1) % NumSources);
        end
    end

    // Advance only when a granted slot completes; aborts keep the pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (ackEdge && |bus.grant) begin
            ptr <= nextPtr;
        end
    end
`else
    assign ptr = '0;
`endif

    // Slot sequencing, arbitration, ack, abort and overrun tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= Idle;
            bus.grant      <= '0;
            bus.null_grant <= 1'b0;
            bus.slot_start <= 1'b0;
            bus.slot_idx   <= '0;
            bus.pkt_idx    <= '0;
            bus.ack        <= '0;
            bus.slot_abort <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.slot_start <= 1'b0;
            bus.slot_abort <= 1'b0;
            bus.ack        <= '0;
            if (startEdge) begin
                state          <= Slot;
                bus.slot_start <= 1'b1;
                bus.slot_idx   <= '0;
                if (fromIdle) begin
                    bus.pkt_idx <= '0;
                end else if (!full) begin
                    bus.pkt_idx <= bus.pkt_idx + 5'd1;
                end
                if (full) begin
                    bus.overrun    <= 1'b1;
                    bus.grant      <= '0;
                    bus.null_grant <= 1'b1;
                end else begin
                    bus.grant      <= winner;
                    bus.null_grant <= ~|bus.req;
                end
            end else if (state == Slot && !inDi) begin
                state          <= Idle;
                bus.slot_abort <= (bus.slot_idx != LastClk);
                bus.grant      <= '0;
                bus.null_grant <= 1'b0;
                bus.slot_idx   <= '0;
                bus.pkt_idx    <= '0;
            end else if (state == Slot) begin
                bus.slot_idx <= bus.slot_idx + 5'd1;
                if (ackEdge) bus.ack <= bus.grant;
            end
        end
    end

endmodule

// File: tb/tb_h14tx_packet_scheduler.sv
// Scoreboard bench for h14tx_packet_scheduler (fixed or RR build).
// Expected slot/ack/abort events are queued; a monitor pops on each event.
module tb_h14tx_packet_scheduler;
    import h14tx_pkg::*;

`ifdef H14TX_SCHED_RR_EN
    localparam bit Rr = 1'b1;
`else
    localparam bit Rr = 1'b0;
`endif

    typedef struct packed {
        logic       st;
        logic       ab;
        logic [3:0] g;
        logic       nl;
        logic [3:0] ak;
        logic [4:0] pk;
        logic [4:0] si;
        logic       ov;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;
    ev_t  expQ[$];

    h14tx_packet_scheduler_if #(.NumSources(4)) bus ();

    h14tx_packet_scheduler #(
        .NumSources (4),
        .MaxPackets (18)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic ev_t mk(bit st, bit ab, logic [3:0] g, bit nl,
                               logic [3:0] ak, int pk, int si, bit ov);
        ev_t e;
        e.st = st; e.ab = ab; e.g = g; e.nl = nl;
        e.ak = ak; e.pk = 5'(pk); e.si = 5'(si); e.ov = ov;
        return e;
    endfunction

    task automatic pushStart(logic [3:0] g, int pk, bit ov);
        expQ.push_back(mk(1'b1, 1'b0, g, (g == 4'd0), 4'd0, pk, 0, ov));
    endtask

    task automatic pushAck(logic [3:0] g, int pk);
        expQ.push_back(mk(1'b0, 1'b0, g, 1'b0, g, pk, 31, 1'b0));
    endtask

    function automatic logic [3:0] rrG(int k);
        logic [3:0] one;
        one = 4'b0001;
        return Rr ? (one << (k % 4)) : one;
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    endtask

    task automatic doReset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        ev_t act;
        ev_t e;
        bus.timings = Control;
        bus.req     = 4'd0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && (bus.slot_start || bus.slot_abort || |bus.ack)) begin
                    act = {bus.slot_start, bus.slot_abort, bus.grant,
                           bus.null_grant, bus.ack, bus.pkt_idx,
                           bus.slot_idx, bus.overrun};
                    total++;
                    if (expQ.size() == 0) begin
                        $display("FAIL unexpected_event act=%h", act);
                    end else begin
                        e = expQ.pop_front();
                        if (act === e) passed++;
                        else $display("FAIL event act st%0b ab%0b g%b n%0b a%b p%0d s%0d o%0b exp st%0b ab%0b g%b n%0b a%b p%0d s%0d o%0b",
                                      act.st, act.ab, act.g, act.nl, act.ak, act.pk, act.si, act.ov,
                                      e.st, e.ab, e.g, e.nl, e.ak, e.pk, e.si, e.ov);
                    end
                end
            end
        join_none

        // reset state
        step(2);
        chk("rst_outs",
            int'({bus.grant, bus.null_grant, bus.slot_start, bus.slot_idx,
                  bus.pkt_idx, bus.ack, bus.slot_abort, bus.overrun}), 0);
        rst = 1'b0;
        step(2);

        // 10-slot island, single requester drops req on ack
        pushStart(4'b0010, 0, 1'b0);
        pushAck(4'b0010, 0);
        for (int k = 1; k < 10; k++) pushStart(4'b0000, k, 1'b0);
        bus.timings = DataIslandActive;
        bus.req     = 4'b0010;
        step(32);
        chk("t1_ack", int'(bus.ack), 2);
        bus.req = 4'd0;
        step(288);
        bus.timings = Control;
        step(3);

        // all requesting, five completed slots
        doReset();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            pushStart(rrG(k), k, 1'b0);
            pushAck(rrG(k), k);
        end
        bus.timings = DataIslandActive;
        step(160);
        bus.timings = Control;
        step(3);

        // abort at slot 2, clock 10; retry in next island
        doReset();
        for (int k = 0; k < 2; k++) begin
            pushStart(rrG(k), k, 1'b0);
            pushAck(rrG(k), k);
        end
        pushStart(rrG(2), 2, 1'b0);
        expQ.push_back(mk(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 0, 0, 1'b0));
        bus.timings = DataIslandActive;
        step(75);
        chk("t3_sidx", int'(bus.slot_idx), 10);
        bus.timings = Control;
        step(1);
        chk("t3_abort_grant", int'(bus.grant), 0);
        step(3);
        pushStart(rrG(2), 0, 1'b0);
        pushAck(rrG(2), 0);
        bus.timings = DataIslandActive;
        step(32);
        bus.timings = Control;
        step(3);
        bus.req = 4'd0;

        // overrun past 18 slots
        doReset();
        bus.req = 4'b0001;
        for (int k = 0; k < 18; k++) begin
            pushStart(4'b0001, k, 1'b0);
            pushAck(4'b0001, k);
        end
        pushStart(4'b0000, 17, 1'b1);
        pushStart(4'b0000, 17, 1'b1);
        bus.timings = DataIslandActive;
        step(640);
        bus.timings = Control;
        step(3);
        chk("t4_overrun_sticky", int'(bus.overrun), 1);

        // async reset mid-slot
        doReset();
        chk("t5_overrun_clr", int'(bus.overrun), 0);
        pushStart(4'b0001, 0, 1'b0);
        bus.timings = DataIslandActive;
        step(16);
        chk("t5_sidx", int'(bus.slot_idx), 15);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_outs",
            int'({bus.grant, bus.null_grant, bus.slot_start, bus.slot_idx,
                  bus.pkt_idx, bus.ack, bus.slot_abort, bus.overrun}), 0);
        #1 rst = 1'b0;
        pushStart(4'b0001, 0, 1'b0);
        pushAck(4'b0001, 0);
        step(32);
        bus.timings = Control;
        step(3);
        bus.req = 4'd0;

        // req on slot-start edge, toggled mid-slot
        doReset();
        pushStart(4'b0100, 0, 1'b0);
        pushAck(4'b0100, 0);
        bus.timings = DataIslandActive;
        bus.req     = 4'b0100;
        step(6);
        bus.req = 4'b0001;
        step(3);
        bus.req = 4'd0;
        chk("t6_grant_held", int'(bus.grant), 4);
        step(23);
        bus.timings = Control;
        step(3);

        chk("queue_drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/h14tx_packet_scheduler.md
Name: h14tx_packet_scheduler

Overview:
Schedules packet transmission into data island active periods. Arbitrates one 32-clock packet slot at a time between NumSources packet requesters and inserts a null packet when nobody requests. Sits between the horizontal timing generator (source of period_t timings) and the packet serializer/TERC4 mux. Its registered grant drives the serializer's source mux.

Parameters:
NumSources, 4, number of packet requesters (index 0 = highest fixed priority)
MaxPackets, 18, slot cap per island; must not exceed the HDMI hard limit of 18

Ports:
clk  input  1  pixel clock
rst  input  1  asynchronous active-high reset
timings  input  period_t  current period from the timing generator
req  input  NumSources  per-source request; level, held until ack
grant  output  NumSources  one-hot owner of the current slot; 0 when idle or null
null_grant  output  1  current slot carries a null packet
slot_start  output  1  pulse on first cycle of each slot
slot_idx  output  5  clock index within slot, 0..31
pkt_idx  output  5  slot number within current island, 0..MaxPackets-1
ack  output  NumSources  one-cycle pulse on the last cycle (slot_idx==31) of a completed slot, to the granted source
slot_abort  output  1  pulse when an island ends mid-slot
overrun  output  1  sticky; set when the island exceeds MaxPackets slots; cleared only by rst

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer 0.
- Latency: all outputs are registered and lag timings by exactly 1 cycle. The downstream serializer delays timings by 1 to align.
- States:
  - IDLE: timings != DataIslandActive.
  - SLOT: inside a slot.
- Transitions:
  - IDLE->SLOT: edge on which timings==DataIslandActive.
  - SLOT->SLOT (new slot): slot_idx==31 and timings still DataIslandActive.
  - SLOT->IDLE: timings != DataIslandActive.
- Arbitration happens on every slot-start edge using req sampled on that edge:
  - grant loads the winner; null_grant=1 if req==0.
  - slot_start=1, slot_idx=0.
  - pkt_idx=0 on entry from IDLE, otherwise pkt_idx+1.
- Within a slot, slot_idx increments every cycle. grant and null_grant are held for all 32 cycles; req changes mid-slot are ignored.
- ack[i] = grant[i] and slot_idx==31 and the slot completes. The source must drop req or present its next packet by the following slot start. A req still high at the next slot start is a new request.
- Abort: if timings leaves DataIslandActive while slot_idx<31:
  - slot_abort pulses.
  - grant and null_grant clear; no ack is issued.
  - The RR pointer is not advanced, so the aborted source retries first.
- Overrun: when a slot would start with pkt_idx==MaxPackets-1 already used, overrun sets and the slot is forced to null_grant regardless of req. pkt_idx saturates at MaxPackets-1.
- A request arriving in the same edge as a slot start is eligible. A request arriving during IDLE waits for the next island.
- Widths: slot_idx wraps 31->0 only at a new slot start; no arithmetic overflow otherwise.

Optional Feature:
H14TX_SCHED_RR_EN.
- Defined: round-robin arbitration. Search starts at the RR pointer. After a completed (acked) non-null slot, the pointer advances to the winner+1 mod NumSources.
- Undefined: fixed priority, lowest index wins. The pointer register is not built.
- Reset, abort and overrun behaviour are identical in both builds.

Decomposition:
- h14tx_pkg gains:
  - SlotClocks=32
  - PacketHardLimit=18
  - slot_idx_t (5 bits)
  - sched_state_e {Idle, Slot}
- period_t and DataIslandActive are reused from h14tx_pkg.
- One sub-module, h14tx_sched_arbiter: combinational one-hot winner from req and the pointer. The pointer is a port, tied to 0 when H14TX_SCHED_RR_EN is undefined.

Test Plan:
- 1280x720 line (1650 total, 1280 active) from the existing timing generator, 10 slots/island, req=4'b0010 constant, ack dropping req → slot 0 grant=0010, ack[1] on its cycle 31; slots 1..9 null_grant=1, pkt_idx 0..9.
- RR build, req=4'b1111 held, acks ignored → grants 0001,0010,0100,1000,0001 over five slots. Fixed build → all five grant 0001.
- Force timings to Control at slot_idx==10 of slot 2 → slot_abort pulse, grant=0, no ack. RR build: the same source wins slot 0 of the next island.
- Hold DataIslandActive for 20 slots with MaxPackets=18, req=4'b0001 → slots 0..17 granted normally, slots 18..19 null_grant=1, overrun=1 and staying set, pkt_idx stuck at 17.
- Assert rst asynchronously at slot_idx==15 → outputs 0 in the same cycle. After release, scheduling restarts at the next DataIslandActive with pkt_idx=0.
- req rises on the same edge as a slot start → granted in that slot. req toggles mid-slot → grant unchanged.
